// File: rtl/pulse_decoder_3x8.sv
`timescale 1ns/1ps
// pulse_decoder_3x8
// Sequential 3-to-8 decoder/dispatcher. Each valid {in} event sets a pending
// bit; pending channels are replayed highest-index first as one-hot strobes
// PULSE_LEN cycles wide, separated by GAP_LEN idle cycles.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   in       in   3  encoded channel index
//   valid    in   1  in is meaningful this cycle
//   out      out  8  registered one-hot strobe, zero when not pulsing
//   code     out  3  registered index currently driven on out, 0 when idle
//   busy     out  1  registered, high whenever the FSM is not IDLE
//   pending  out  8  registered queue of received, not-yet-serviced channels
//   dup      out  1  registered 1-cycle flag: event merged into a pending bit
module pulse_decoder_3x8 #(
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in,
  input  logic       valid,
  output logic [7:0] out,
  output logic [2:0] code,
  output logic       busy,
  output logic [7:0] pending,
  output logic       dup
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam bit         GAP_EN   = (GAP_LEN > 0);
  localparam logic [7:0] PULSE_M1 = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_M1   = GAP_EN ? 8'(GAP_LEN - 1) : 8'h00;

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [7:0] out_r, out_s;
  logic [2:0] code_r, code_s;
  logic       busy_r;
  logic [7:0] pending_r, pending_s;
  logic       dup_r, dup_s;
  logic       select_s;
  logic [2:0] sel_idx_s;
  logic [7:0] set_mask_s, clr_mask_s;

  // Highest set bit of v; later (higher) indices override earlier ones.
  function automatic logic [2:0] top_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Pending-queue update and duplicate detection; set wins over clear.
  always_comb begin
    sel_idx_s  = top_idx(pending_r);
    clr_mask_s = select_s ? (8'h01 << sel_idx_s) : 8'h00;
    set_mask_s = valid ? (8'h01 << in) : 8'h00;
    pending_s  = (pending_r & ~clr_mask_s) | set_mask_s;
    dup_s      = valid & pending_r[in] & ~clr_mask_s[in];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; select_s marks an edge that launches a new strobe.
  always_comb begin
    state_s  = state_r;
    select_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pending_r != 8'h00) begin
          state_s  = PULSE;
          select_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      PULSE: begin
        if (cnt_r == 8'h00) begin
          if (GAP_EN) begin
            state_s = GAP;
          end else if (pending_r != 8'h00) begin
            // No gap configured: chain straight into the next strobe.
            state_s  = PULSE;
            select_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = PULSE;
        end
      end
      GAP: begin
        if (cnt_r == 8'h00) begin
          if (pending_r != 8'h00) begin
            state_s  = PULSE;
            select_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output/counter logic derived from the transition being taken.
  always_comb begin
    cnt_s  = cnt_r;
    out_s  = out_r;
    code_s = code_r;
    if (select_s) begin
      cnt_s  = PULSE_M1;
      out_s  = 8'h01 << sel_idx_s;
      code_s = sel_idx_s;
    end else if ((state_r == PULSE) && (state_s == GAP)) begin
      cnt_s  = GAP_M1;
      out_s  = 8'h00;
      code_s = 3'd0;
    end else if (state_s == IDLE) begin
      cnt_s  = 8'h00;
      out_s  = 8'h00;
      code_s = 3'd0;
    end else begin
      // Staying in PULSE or GAP implies a non-zero count.
      cnt_s = cnt_r - 8'd1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= 8'h00;
      out_r     <= 8'h00;
      code_r    <= 3'd0;
      busy_r    <= 1'b0;
      pending_r <= 8'h00;
      dup_r     <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      out_r     <= out_s;
      code_r    <= code_s;
      busy_r    <= (state_s != IDLE);
      pending_r <= pending_s;
      dup_r     <= dup_s;
    end
  end

  assign out     = out_r;
  assign code    = code_r;
  assign busy    = busy_r;
  assign pending = pending_r;
  assign dup     = dup_r;

endmodule

// File: tb/tb_pulse_decoder_3x8.sv
`timescale 1ns/1ps
// Directed self-checking bench for pulse_decoder_3x8: one instance with the
// default timing (PULSE_LEN=2, GAP_LEN=1) and one with PULSE_LEN=1, GAP_LEN=0.
module tb_pulse_decoder_3x8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_a, in_b;
  logic       valid_a, valid_b;
  logic [7:0] out_a, out_b, pending_a, pending_b;
  logic [2:0] code_a, code_b;
  logic       busy_a, busy_b, dup_a, dup_b;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle stimulus and expected values for the default instance.
  logic       sv[16];
  logic [2:0] si[16];
  logic [7:0] so[16];
  logic [7:0] sp[16];
  logic       sb[16];
  logic       sd[16];

  pulse_decoder_3x8 #(.PULSE_LEN(2), .GAP_LEN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .valid(valid_a),
    .out(out_a), .code(code_a), .busy(busy_a), .pending(pending_a), .dup(dup_a)
  );

  pulse_decoder_3x8 #(.PULSE_LEN(1), .GAP_LEN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .valid(valid_b),
    .out(out_b), .code(code_b), .busy(busy_b), .pending(pending_b), .dup(dup_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Index of the single set bit of a one-hot value (0 for zero).
  function automatic logic [2:0] idx_of(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  task automatic run_a(input string tag);
    for (int c = 0; c < 16; c++) begin
      valid_a = sv[c];
      in_a    = si[c];
      tick();
      check($sformatf("%s.out[%0d]", tag, c), 32'(out_a), 32'(so[c]));
      check($sformatf("%s.code[%0d]", tag, c), 32'(code_a), 32'(idx_of(so[c])));
      check($sformatf("%s.busy[%0d]", tag, c), 32'(busy_a), 32'(sb[c]));
      check($sformatf("%s.pend[%0d]", tag, c), 32'(pending_a), 32'(sp[c]));
      check($sformatf("%s.dup[%0d]", tag, c), 32'(dup_a), 32'(sd[c]));
    end
    valid_a = 1'b0;
    in_a    = 3'd0;
  endtask

  task automatic check_a_all_zero(input string tag);
    check({tag, ".out"},  32'(out_a),     32'h0);
    check({tag, ".code"}, 32'(code_a),    32'h0);
    check({tag, ".busy"}, 32'(busy_a),    32'h0);
    check({tag, ".pend"}, 32'(pending_a), 32'h0);
    check({tag, ".dup"},  32'(dup_a),     32'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    in_a    = 3'd0;
    valid_a = 1'b0;
    in_b    = 3'd0;
    valid_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_a_all_zero("reset");
    check("reset.b_out", 32'(out_b), 32'h0);
    check("reset.b_busy", 32'(busy_b), 32'h0);
    rst_n = 1'b1;
    tick();
    tick();

    // Single event on channel 5.
    sv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    si = '{3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    so = '{8'h00, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sp = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    sd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_a("single");

    // Ordering: 1 already selected when 6 arrives.
    sv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    si = '{3'd1, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    so = '{8'h00, 8'h02, 8'h02, 8'h00, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sp = '{8'h02, 8'h40, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_a("order");

    // Priority: 2, 7, 4 arrive while strobe 0 is active.
    sv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    si = '{3'd0, 3'd0, 3'd2, 3'd7, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    so = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h00, 8'h10, 8'h10, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    sp = '{8'h01, 8'h00, 8'h04, 8'h84, 8'h14, 8'h14, 8'h14, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    run_a("prio");

    // Duplicate: second 3 merges into pending bit 3 while 7 is strobing.
    sv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    si = '{3'd7, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    so = '{8'h00, 8'h80, 8'h80, 8'h00, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sp = '{8'h80, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    sd = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_a("dup");

    // Retrigger: 3 re-requested on its own selection edge.
    sv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    si = '{3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    so = '{8'h00, 8'h08, 8'h08, 8'h00, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sp = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    sd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_a("retrig");

    // No-gap instance: 7 then 0 give back-to-back strobes 0x80, 0x01.
    valid_b = 1'b1;
    in_b    = 3'd7;
    tick();
    check("nogap.c0.out", 32'(out_b), 32'h00);
    check("nogap.c0.pend", 32'(pending_b), 32'h80);
    in_b = 3'd0;
    tick();
    check("nogap.c1.out", 32'(out_b), 32'h80);
    check("nogap.c1.code", 32'(code_b), 32'd7);
    check("nogap.c1.busy", 32'(busy_b), 32'h1);
    check("nogap.c1.pend", 32'(pending_b), 32'h01);
    valid_b = 1'b0;
    tick();
    check("nogap.c2.out", 32'(out_b), 32'h01);
    check("nogap.c2.code", 32'(code_b), 32'd0);
    check("nogap.c2.busy", 32'(busy_b), 32'h1);
    check("nogap.c2.pend", 32'(pending_b), 32'h00);
    tick();
    check("nogap.c3.out", 32'(out_b), 32'h00);
    check("nogap.c3.busy", 32'(busy_b), 32'h0);

    // Reset mid-pulse with 0x05 still pending.
    valid_a = 1'b1;
    in_a    = 3'd5;
    tick();
    in_a = 3'd2;
    tick();
    in_a = 3'd0;
    tick();
    valid_a = 1'b0;
    check("rstmid.pre.out", 32'(out_a), 32'h20);
    check("rstmid.pre.pend", 32'(pending_a), 32'h05);
    #2;
    rst_n = 1'b0;
    #1;
    check_a_all_zero("rstmid.async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rstmid.quiet[%0d].out", c), 32'(out_a), 32'h00);
      check($sformatf("rstmid.quiet[%0d].busy", c), 32'(busy_a), 32'h0);
      check($sformatf("rstmid.quiet[%0d].pend", c), 32'(pending_a), 32'h00);
    end
    valid_a = 1'b1;
    in_a    = 3'd4;
    tick();
    valid_a = 1'b0;
    check("rstmid.new.pend", 32'(pending_a), 32'h10);
    tick();
    check("rstmid.new.out", 32'(out_a), 32'h10);
    check("rstmid.new.code", 32'(code_a), 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
